// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side checker and its helpers.
package fifo_pkg;

  localparam int unsigned FIFO_DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FULL = 2'd1,
    READ      = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_check.sv
// Read-side consumer for the async FIFO: waits for full, drains in bursts and
// checks the data form an incrementing modulo-2^DW sequence.
module fifo_rd_check
  import fifo_pkg::*;
#(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             rd_rst_busy,
  input  logic             full,
  input  logic             empty,
  input  logic             almost_empty,
  input  logic [DW-1:0]    fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             busy
);

  logic          full_s;
  rd_state_e     state;
  logic          rd_vld;
  logic          seeded;
  logic [DW-1:0] expected;
  logic          ae_dbg_unused;

  sync_2ff u_full_sync (
    .clk (rd_clk),
    .rst (rst),
    .d   (full),
    .q   (full_s)
  );

  // Gated combinationally so a read is never issued on an empty FIFO.
  assign fifo_rd_en = (state == READ) & ~empty & ~rd_rst_busy;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else if (rd_rst_busy) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= WAIT_FULL;
          busy  <= 1'b0;
        end
        WAIT_FULL: begin
          if (full_s) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (empty) begin
            state     <= WAIT_FULL;
            busy      <= 1'b0;
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Checker runs off rd_vld alone, so a word in flight when the FSM leaves
  // READ (or when rd_rst_busy rises) is still checked.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_vld        <= 1'b0;
      seeded        <= 1'b0;
      expected      <= '0;
      err_flag      <= 1'b0;
      err_cnt       <= '0;
      word_cnt      <= '0;
      ae_dbg_unused <= 1'b0;
    end else begin
      rd_vld        <= fifo_rd_en;
      ae_dbg_unused <= almost_empty;
      if (rd_vld) begin
        word_cnt <= word_cnt + CNT_W'(1);
        expected <= fifo_rd_data + DW'(1);
        if (!seeded) begin
          seeded <= 1'b1;
        end else if (fifo_rd_data != expected) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_check.sv
// Bench for fifo_rd_check: FIFO modelled as a queue, checker modelled from the
// sequence rules, compared every cycle, plus directed literal checks.
module tb_fifo_rd_check;

  logic        clk;
  logic        rst;
  logic        rd_rst_busy;
  logic        full;
  logic        empty;
  logic        almost_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic [31:0] burst_cnt;
  logic        busy;

  fifo_rd_check #(
    .DW    (8),
    .CNT_W (32),
    .ERR_W (16)
  ) dut (
    .rd_clk       (clk),
    .rst          (rst),
    .rd_rst_busy  (rd_rst_busy),
    .full         (full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .err_flag     (err_flag),
    .err_cnt      (err_cnt),
    .word_cnt     (word_cnt),
    .burst_cnt    (burst_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          fails   = 0;
  logic        chk_en  = 1'b0;

  logic [7:0]  q[$];
  logic        pend_v  = 1'b0;
  logic [7:0]  pend_d  = '0;
  logic        drained = 1'b0;

  logic        m_seeded = 1'b0;
  logic [7:0]  m_exp    = '0;
  int unsigned m_err    = 0;
  logic        m_flag   = 1'b0;
  int unsigned m_words  = 0;
  int unsigned m_bursts = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    vectors++;
    fails++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  function automatic void model_reset();
    m_seeded = 1'b0;
    m_exp    = '0;
    m_err    = 0;
    m_flag   = 1'b0;
    m_words  = 0;
    m_bursts = 0;
  endfunction

  function automatic void model_word(input logic [7:0] d);
    if (!m_seeded) begin
      m_seeded = 1'b1;
    end else if (d != m_exp) begin
      m_flag = 1'b1;
      if (m_err < 65535) m_err++;
    end
    m_exp = d + 8'd1;
    m_words++;
  endfunction

  // One clock: FIFO pops on an accepted read, data valid the next cycle.
  task automatic step();
    logic acc, rst_e, rrb_e;
    @(negedge clk);
    acc   = fifo_rd_en;
    rst_e = rst;
    rrb_e = rd_rst_busy;
    @(posedge clk);
    #1;
    if (rst_e) begin
      model_reset();
      pend_v  = 1'b0;
      drained = 1'b0;
    end else begin
      if (pend_v) model_word(pend_d);
      if (drained && !rrb_e) m_bursts++;
      pend_v  = 1'b0;
      drained = 1'b0;
    end
    if (acc && q.size() > 0) begin
      fifo_rd_data = q.pop_front();
      full = 1'b0;
      if (!rst_e) begin
        pend_v = 1'b1;
        pend_d = fifo_rd_data;
        if (q.size() == 0) drained = 1'b1;
      end
    end
    empty        = (q.size() == 0);
    almost_empty = (q.size() == 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("err_cnt", err_cnt, m_err);
      chk("err_flag", err_flag, m_flag);
      chk("word_cnt", word_cnt, m_words);
      chk("burst_cnt", burst_cnt, m_bursts);
      if (fifo_rd_en) chk("rd_en_gate", {empty, rd_rst_busy}, 0);
    end
  end

  task automatic do_reset(input logic clear_q);
    rst = 1'b1;
    if (clear_q) begin
      q.delete();
      full = 1'b0;
      empty = 1'b1;
      almost_empty = 1'b0;
    end
    step();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_busy", busy, 0);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load_seq(input int n, input logic [7:0] start);
    logic [7:0] d;
    d = start;
    for (int i = 0; i < n; i++) begin
      q.push_back(d);
      d = d + 8'd1;
    end
    empty = (q.size() == 0);
    almost_empty = (q.size() == 1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (!(q.size() == 0 && !pend_v && busy == 1'b0)) begin
      if (n >= bound) begin
        timeout_fail("drain");
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] nxt;
    logic [7:0] glitch[6];
    rst = 1'b1; rd_rst_busy = 1'b0; full = 1'b0; empty = 1'b1;
    almost_empty = 1'b0; fifo_rd_data = '0;

    // Preload 0..15 and measure full-to-read latency.
    do_reset(1'b1);
    step();
    load_seq(16, 8'd0);
    full = 1'b1;
    n = 0;
    while (!fifo_rd_en && n < 10) begin step(); n++; end
    chk("full_to_rd_en_cycles", n, 3);
    drain(100);
    chk("t1_word_cnt", word_cnt, 16);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_burst_cnt", burst_cnt, 1);

    // Wrap 250..255,0..9 is legal.
    do_reset(1'b1);
    load_seq(16, 8'd250);
    full = 1'b1;
    drain(100);
    chk("wrap_err_cnt", err_cnt, 0);
    chk("wrap_word_cnt", word_cnt, 16);

    // Single discontinuity counts once.
    do_reset(1'b1);
    glitch = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
    for (int i = 0; i < 6; i++) q.push_back(glitch[i]);
    empty = 1'b0;
    full = 1'b1;
    drain(100);
    chk("glitch_err_cnt", err_cnt, 1);
    chk("glitch_err_flag", err_flag, 1);
    chk("glitch_word_cnt", word_cnt, 6);

    // rd_rst_busy after 4 reads of 16, then resume.
    do_reset(1'b1);
    load_seq(16, 8'd0);
    full = 1'b1;
    n = 0;
    while (q.size() > 12 && n < 50) begin step(); n++; end
    rd_rst_busy = 1'b1;
    #1;
    chk("rrb_rd_en_same_cycle", fifo_rd_en, 0);
    step();
    chk("rrb_busy", busy, 0);
    chk("rrb_word_cnt", word_cnt, 4);
    step();
    chk("rrb_queue_left", q.size(), 12);
    rd_rst_busy = 1'b0;
    step();
    full = 1'b1;
    drain(100);
    chk("rrb_resume_word_cnt", word_cnt, 16);
    chk("rrb_resume_err_cnt", err_cnt, 0);
    chk("rrb_resume_burst_cnt", burst_cnt, 1);

    // rst mid-burst after 5 reads; one more read is lost under reset.
    do_reset(1'b1);
    load_seq(16, 8'd0);
    full = 1'b1;
    n = 0;
    while (q.size() > 11 && n < 50) begin step(); n++; end
    do_reset(1'b0);
    chk("midrst_queue_left", q.size(), 10);
    full = 1'b1;
    drain(100);
    chk("midrst_word_cnt", word_cnt, 10);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_burst_cnt", burst_cnt, 1);

    // Randomized bursts with glitches and rd_rst_busy pulses.
    do_reset(1'b1);
    nxt = 8'($urandom);
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : nxt;
        q.push_back(d);
        nxt = d + 8'd1;
      end
      empty = 1'b0;
      almost_empty = (q.size() == 1);
      full = 1'b1;
      n = 0;
      while (!(q.size() == 0 && !pend_v && busy == 1'b0)) begin
        if (n >= 500) begin timeout_fail("rand_drain"); break; end
        if ($urandom_range(0, 15) == 0) begin
          rd_rst_busy = 1'b1;
          repeat ($urandom_range(1, 3)) begin step(); n++; end
          rd_rst_busy = 1'b0;
          if (q.size() > 0) full = 1'b1;
        end
        step();
        n++;
      end
    end

    // Saturation: 70000 mismatches after the seed word.
    do_reset(1'b1);
    for (int i = 0; i < 70001; i++) q.push_back(8'd0);
    empty = 1'b0;
    full = 1'b1;
    drain(80000);
    chk("sat_err_cnt", err_cnt, 65535);
    chk("sat_err_flag", err_flag, 1);
    chk("sat_word_cnt", word_cnt, 70001);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_check.md
# fifo_rd_check

Read-side consumer and data checker for the asynchronous FIFO, running in the read clock domain. Waits for the FIFO to fill, drains it in bursts, and checks that the read data form the incrementing modulo-2^DW sequence the write side produces. Exposes sticky error status and word/burst counters for ILA or LED observation.

## Interface
- DW, 8: FIFO data width.
- CNT_W, 32: width of the word and burst counters.
- ERR_W, 16: width of the error counter.

Ports (one clock; reset is synchronous and active-high):
- rd_clk  in  1  read-domain clock; all state is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_rst_busy  in  1  FIFO read-side reset in progress.
- full  in  1  FIFO full; this is a write-domain signal.
- empty  in  1  FIFO empty (read domain).
- almost_empty  in  1  one word left (read domain).
- fifo_rd_data  in  DW  FIFO dout; valid one cycle after an accepted read.
- fifo_rd_en  out  1  read request to the FIFO.
- err_flag  out  1  sticky flag: a mismatch has been seen.
- err_cnt  out  ERR_W  mismatch count; saturates at all-ones.
- word_cnt  out  CNT_W  count of words checked; wraps.
- burst_cnt  out  CNT_W  count of completed drain bursts; wraps.
- busy  out  1  high while in the READ state.

## Operation
- full is passed through a 2-flop synchronizer to give full_s.
- State machine:
  - IDLE -> WAIT_FULL when rd_rst_busy=0.
  - WAIT_FULL -> READ when full_s=1.
  - READ -> WAIT_FULL on the cycle empty=1; burst_cnt increments on that transition.
  - Any state -> IDLE when rd_rst_busy=1.
- fifo_rd_en = (state==READ) & ~empty & ~rd_rst_busy. This is combinational, so no read is ever issued while empty.
- An accepted read sets rd_vld on the next cycle (1-cycle read latency, standard non-FWFT FIFO).
- Checking on each rd_vld cycle:
  - First word after reset (seeded=0): no comparison. Set expected = data+1 and seeded=1.
  - Later words: compare fifo_rd_data with expected.
  - On mismatch: err_cnt +1 (saturating), err_flag set. Expected resyncs to data+1, so a single glitch counts once.
  - In all cases expected = data+1, truncated to DW bits. 2^DW-1 is followed by 0 with no error.
  - word_cnt +1 on every rd_vld, including the seed word.
- A word in flight (rd_vld) when the FSM leaves READ is still checked.
- almost_empty is informational only. It is registered for debug and does not affect control.

## Timing
- Reset values: fifo_rd_en=0, err_flag=0, err_cnt=0, word_cnt=0, burst_cnt=0, busy=0. State is IDLE, seeded=0, expected=0, sync flops 0.
- Reset asserted mid-burst: in the cycle after the rst edge, all of the above are restored. Any pending rd_vld is discarded.
- full to READ latency: 3 rd_clk cycles (2 sync flops plus 1 state register).
- In READ, one word is read per cycle while empty=0. The last read is in the cycle before empty rises.
- rd_rst_busy rising mid-burst:
  - fifo_rd_en drops in the same cycle.
  - A read accepted in the prior cycle is still checked.
  - Counters and err state are held, not cleared.
- Simultaneous empty=1 and rd_rst_busy=1: go to IDLE; burst_cnt does not increment.
- busy equals (state==READ), registered.

## Structure
- Shared package fifo_pkg:
  - State enum (IDLE, WAIT_FULL, READ), 2-bit encoding.
  - Default DW.
- Sub-module sync_2ff (1-bit, reset to 0). It is reused for other cross-domain flags such as empty on the write side.
- The FSM, read-enable logic and checker all live in fifo_rd_check. Expected size is about 150 lines.

## Test plan
- Reset release, FIFO model preloaded with 0..15, full=1:
  - fifo_rd_en first high 3 cycles after full.
  - 16 reads; word_cnt=16, err_cnt=0, burst_cnt=1.
- Sequence 250..255,0..9: no errors; wrap accepted.
- Sequence 0,1,2,7,8,9: err_cnt=1, err_flag=1; subsequent words accepted.
- rd_rst_busy pulsed after 4 reads of 16:
  - fifo_rd_en low the same cycle; FSM in IDLE; word_cnt=4 (including the in-flight word).
  - Resumes on the next full.
- rst asserted mid-burst: every output 0 the next cycle. The first word afterwards re-seeds with no error.
- 70000 mismatches with ERR_W=16: err_cnt holds at 65535.
